data_mem_be: RTL and testbench

- Parametrised successor of the core's single-cycle data memory.
- Adds per-byte write enables, configurable access latency with a ready handshake, and a parametrised word depth.
- Sits between the core LSU and the memory map; the core holds its request until `ready_o` pulses and stalls meanwhile.

---
 rtl/data_mem_be_pkg.sv | 15 +
 rtl/data_mem_be_if.sv | 33 +++
 rtl/data_mem_be_bank.sv | 32 +++
 rtl/data_mem_be.sv | 140 ++++++++++++++
 tb/tb_data_mem_be.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_be_pkg.sv
// Shared types and constants for the byte-enable data memory.
// Optional build macro used elsewhere: DATA_MEM_ERR_EN.
package data_mem_pkg;

    localparam logic [31:0] DMEM_FILL_WR  = 32'hFA11_1EAF;
    localparam logic [31:0] DMEM_FILL_OOR = 32'hDEAD_BEEF;
    localparam int          LAT_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/data_mem_be_if.sv
// LSU <-> data memory request/response bundle.
// Optional build macro: DATA_MEM_ERR_EN adds the mem_err_o response flag.
interface data_mem_be_if #(
    parameter int DATA_W = 32
);
    logic                  mem_req_i;
    logic                  write_enable_i;
    logic [DATA_W/8-1:0]   byte_enable_i;
    logic [31:0]           addr_i;
    logic [DATA_W-1:0]     write_data_i;
    logic                  ready_o;
    logic [DATA_W-1:0]     read_data_o;
`ifdef DATA_MEM_ERR_EN
    logic                  mem_err_o;
`endif

    modport master (
        output mem_req_i, write_enable_i, byte_enable_i, addr_i, write_data_i,
`ifdef DATA_MEM_ERR_EN
        input  mem_err_o,
`endif
        input  ready_o, read_data_o
    );

    modport slave (
        input  mem_req_i, write_enable_i, byte_enable_i, addr_i, write_data_i,
`ifdef DATA_MEM_ERR_EN
        output mem_err_o,
`endif
        output ready_o, read_data_o
    );

endinterface

// File: rtl/data_mem_be_bank.sv
// Word-organised RAM with per-byte write strobes and a registered read port.
// Read returns the pre-write contents when reading and writing the same word.
module data_mem_bank #(
    parameter int DEPTH_WORDS = 4096,
    parameter int DATA_W      = 32
) (
    input  logic                           clk_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic                           we_i,
    input  logic [DATA_W/8-1:0]            be_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [DATA_W-1:0]              rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Byte-masked write and registered read; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_be.sv
// Data memory with byte enables, fixed access latency and ready handshake.
// Optional build macro: DATA_MEM_ERR_EN (adds mem_err_o on out-of-range or
// misaligned accesses).
//
// state | meaning
// IDLE  | waiting for mem_req_i; request accepted (and writes committed) here
// WAIT  | latency countdown, all inputs ignored
// RESP  | ready_o pulse, response data presented
module data_mem_be
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1,
    parameter int DATA_W      = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    data_mem_be_if.slave  bus
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    dmem_state_t          state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 is_wr_q, is_wr_d;
    logic                 oor_q, oor_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [DATA_W-1:0]    bank_rd;
    logic [DATA_W-1:0]    resp_data;
    logic [IDX_W-1:0]     bank_idx;
    logic                 in_range;
    logic                 accept;
    logic                 bank_we;
`ifdef DATA_MEM_ERR_EN
    logic                 err_q, err_d;
`endif

    assign in_range = ({1'b0, bus.addr_i} < ADDR_LIMIT);
    assign accept   = (state_q == IDLE) && bus.mem_req_i;
    assign bank_we  = accept && bus.write_enable_i && in_range;
    // The bank samples the live address at acceptance, then keeps re-reading
    // the captured word (unchanged, since writes only happen at acceptance).
    assign bank_idx = (state_q == IDLE) ? bus.addr_i[IDX_W+1:2] : idx_q;

    data_mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W)
    ) u_bank (
        .clk_i   (clk_i),
        .idx_i   (bank_idx),
        .we_i    (bank_we),
        .be_i    (bus.byte_enable_i),
        .wdata_i (bus.write_data_i),
        .rdata_o (bank_rd)
    );

    assign resp_data = is_wr_q ? DATA_W'(DMEM_FILL_WR)
                     : oor_q   ? DATA_W'(DMEM_FILL_OOR)
                     :           bank_rd;

    // Next-state, countdown and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        oor_d   = oor_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
`ifdef DATA_MEM_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_wr_d = bus.write_enable_i;
                    oor_d   = !in_range;
                    idx_d   = bus.addr_i[IDX_W+1:2];
`ifdef DATA_MEM_ERR_EN
                    err_d   = !in_range || (bus.addr_i[1:0] != 2'b00);
`endif
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = resp_data;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
`ifdef DATA_MEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            oor_q   <= oor_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
`ifdef DATA_MEM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // In RESP the response is shown straight from registered sources (this is
    // what makes LATENCY=1 work with a registered RAM); it is latched into
    // rdata_q on leaving RESP so the output holds afterwards.
    assign bus.ready_o     = (state_q == RESP);
    assign bus.read_data_o = (state_q == RESP) ? resp_data : rdata_q;
`ifdef DATA_MEM_ERR_EN
    assign bus.mem_err_o   = (state_q == RESP) && err_q;
`endif

endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be with three latency configurations.
module tb_data_mem_be;
    import data_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_be_if #(.DATA_W(32)) if1 ();
    data_mem_be_if #(.DATA_W(32)) if4 ();
    data_mem_be_if #(.DATA_W(32)) if6 ();

    data_mem_be #(.DEPTH_WORDS(4096), .LATENCY(1), .DATA_W(32)) u_lat1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));
    data_mem_be #(.DEPTH_WORDS(256), .LATENCY(4), .DATA_W(32)) u_lat4 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if4.slave));
    data_mem_be #(.DEPTH_WORDS(256), .LATENCY(6), .DATA_W(32)) u_lat6 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if6.slave));

    task automatic drive(input int sel, input logic req, input logic we,
                         input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd);
        case (sel)
            1: begin if1.mem_req_i = req; if1.write_enable_i = we; if1.byte_enable_i = be;
                     if1.addr_i = addr; if1.write_data_i = wd; end
            4: begin if4.mem_req_i = req; if4.write_enable_i = we; if4.byte_enable_i = be;
                     if4.addr_i = addr; if4.write_data_i = wd; end
            default: begin if6.mem_req_i = req; if6.write_enable_i = we; if6.byte_enable_i = be;
                     if6.addr_i = addr; if6.write_data_i = wd; end
        endcase
    endtask

    task automatic sample(input int sel, output logic rdy, output logic [31:0] rd,
                          output logic err);
        err = 1'b0;
        case (sel)
            1: begin rdy = if1.ready_o; rd = if1.read_data_o;
`ifdef DATA_MEM_ERR_EN
                     err = if1.mem_err_o;
`endif
               end
            4: begin rdy = if4.ready_o; rd = if4.read_data_o;
`ifdef DATA_MEM_ERR_EN
                     err = if4.mem_err_o;
`endif
               end
            default: begin rdy = if6.ready_o; rd = if6.read_data_o;
`ifdef DATA_MEM_ERR_EN
                     err = if6.mem_err_o;
`endif
               end
        endcase
    endtask

    // One request; lat counts rising edges from acceptance (acceptance = 1)
    // until ready_o is seen; -1 means it never came.
    task automatic access(input int sel, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output logic err);
        logic rdy;
        lat = -1;
        @(negedge clk);
        drive(sel, 1'b1, we, be, addr, wd);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            sample(sel, rdy, rd, err);
            if (rdy) begin
                lat = i;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0, 0);
        drive(6, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (if1.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_l1 got %b exp 0", if1.ready_o); end
        checks++; if (if1.read_data_o !== 32'h0) begin errors++; $display("FAIL reset_data_l1 got %h exp 0", if1.read_data_o); end
        checks++; if (if4.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_l4 got %b exp 0", if4.ready_o); end
        checks++; if (if4.read_data_o !== 32'h0) begin errors++; $display("FAIL reset_data_l4 got %h exp 0", if4.read_data_o); end
        checks++; if (if6.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_l6 got %b exp 0", if6.ready_o); end
        checks++; if (if6.read_data_o !== 32'h0) begin errors++; $display("FAIL reset_data_l6 got %h exp 0", if6.read_data_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; int lat; logic err;
        access(1, 1, 4'hF, 32'h10, 32'h1234_5678, rd, lat, err);
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency got %0d exp 1", lat); end
        checks++; if (rd !== 32'hFA11_1EAF) begin errors++; $display("FAIL wr_fill got %h exp fa111eaf", rd); end
        access(1, 0, 4'h0, 32'h10, 32'h0, rd, lat, err);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rd_latency got %0d exp 1", lat); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h exp 12345678", rd); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; int lat; logic err;
        access(1, 1, 4'hF, 32'h20, 32'hAABB_CCDD, rd, lat, err);
        access(1, 1, 4'h5, 32'h20, 32'h1122_3344, rd, lat, err);
        access(1, 0, 4'h0, 32'h20, 32'h0, rd, lat, err);
        checks++; if (rd !== 32'hAA22_CC44) begin errors++; $display("FAIL be_merge got %h exp aa22cc44", rd); end
        access(1, 1, 4'h0, 32'h20, 32'hFFFF_FFFF, rd, lat, err);
        checks++; if (lat !== 1 || rd !== 32'hFA11_1EAF) begin errors++; $display("FAIL be_zero_resp got lat %0d data %h exp lat 1 data fa111eaf", lat, rd); end
        access(1, 0, 4'h0, 32'h20, 32'h0, rd, lat, err);
        checks++; if (rd !== 32'hAA22_CC44) begin errors++; $display("FAIL be_zero_noop got %h exp aa22cc44", rd); end
    endtask

    task automatic test_latency();
        logic [31:0] rd; int lat; logic err;
        access(4, 1, 4'hF, 32'h4, 32'h0F0F_0F0F, rd, lat, err);
        checks++; if (lat !== 4) begin errors++; $display("FAIL lat4_wr got %0d exp 4", lat); end
        access(4, 0, 4'h0, 32'h4, 32'h0, rd, lat, err);
        checks++; if (lat !== 4 || rd !== 32'h0F0F_0F0F) begin errors++; $display("FAIL lat4_rd got lat %0d data %h exp lat 4 data 0f0f0f0f", lat, rd); end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, pulses = 0;
        logic [31:0] d2 = 32'h0;
        @(negedge clk);
        drive(4, 1, 0, 4'h0, 32'h4, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (if4.ready_o) begin
                pulses++;
                if (first < 0) first = i;
                else if (second < 0) begin second = i; d2 = if4.read_data_o; end
            end
        end
        drive(4, 0, 0, 4'h0, 32'h0, 32'h0);
        checks++; if (pulses !== 2 || first !== 4) begin errors++; $display("FAIL b2b_first got pulses %0d at %0d exp 2 at 4", pulses, first); end
        checks++; if (second !== 9) begin errors++; $display("FAIL b2b_spacing got %0d exp 9", second); end
        checks++; if (d2 !== 32'h0F0F_0F0F) begin errors++; $display("FAIL b2b_data got %h exp 0f0f0f0f", d2); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; int lat; logic err;
        access(1, 1, 4'hF, 32'h0, 32'h0BAD_F00D, rd, lat, err);
        access(1, 0, 4'h0, 32'h4000, 32'h0, rd, lat, err);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_read got %h exp deadbeef", rd); end
`ifdef DATA_MEM_ERR_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_read_err got %b exp 1", err); end
`endif
        access(1, 1, 4'hF, 32'h4000, 32'hFFFF_FFFF, rd, lat, err);
        checks++; if (lat !== 1 || rd !== 32'hFA11_1EAF) begin errors++; $display("FAIL oor_write_resp got lat %0d data %h exp lat 1 data fa111eaf", lat, rd); end
`ifdef DATA_MEM_ERR_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_write_err got %b exp 1", err); end
`endif
        access(1, 0, 4'h0, 32'h0, 32'h0, rd, lat, err);
        checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL oor_word0 got %h exp 0badf00d", rd); end
`ifdef DATA_MEM_ERR_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL inrange_err got %b exp 0", err); end
`endif
        access(1, 1, 4'hF, 32'h3FFC, 32'h0000_0077, rd, lat, err);
        access(1, 0, 4'h0, 32'h3FFC, 32'h0, rd, lat, err);
        checks++; if (rd !== 32'h0000_0077) begin errors++; $display("FAIL last_word got %h exp 00000077", rd); end
        access(1, 0, 4'h0, 32'h12, 32'h0, rd, lat, err);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL unaligned_read got %h exp 12345678", rd); end
`ifdef DATA_MEM_ERR_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL unaligned_err got %b exp 1", err); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic err;
        logic saw_ready = 1'b0;
        access(6, 1, 4'hF, 32'h8, 32'hCAFE_0001, rd, lat, err);
        checks++; if (lat !== 6) begin errors++; $display("FAIL lat6_wr got %0d exp 6", lat); end
        @(negedge clk);
        drive(6, 1, 1, 4'hF, 32'hC, 32'h5555_AAAA);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive(6, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (if6.ready_o !== 1'b0) saw_ready = 1'b1;
        end
        checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", saw_ready); end
        checks++; if (if6.read_data_o !== 32'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", if6.read_data_o); end
        checks++; if (u_lat6.state_q !== IDLE) begin errors++; $display("FAIL midrst_state got %0d exp IDLE", u_lat6.state_q); end
        rst_n = 1'b1;
        access(6, 0, 4'h0, 32'hC, 32'h0, rd, lat, err);
        checks++; if (lat !== 6 || rd !== 32'h5555_AAAA) begin errors++; $display("FAIL midrst_commit got lat %0d data %h exp lat 6 data 5555aaaa", lat, rd); end
        access(6, 0, 4'h0, 32'h8, 32'h0, rd, lat, err);
        checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL midrst_keep got %h exp cafe0001", rd); end
    endtask

    task automatic test_idle();
        logic [31:0] rd; int lat; logic err;
        logic bad = 1'b0;
        access(1, 0, 4'h0, 32'h10, 32'h0, rd, lat, err);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL idle_pre got %h exp 12345678", rd); end
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.ready_o !== 1'b0 || if1.read_data_o !== 32'h1234_5678) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL idle_hold got ready %b data %h exp 0 12345678", if1.ready_o, if1.read_data_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_byte_enable();
        test_latency();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
